// File: rtl/dealer_pkg.sv
// rtl/dealer_pkg.sv - shared motor_state codes, coil phase table and player bounds
package dealer_pkg;

  typedef enum logic [1:0] {
    MS_RESET  = 2'b00,
    MS_ROTATE = 2'b01,
    MS_WAIT   = 2'b10,
    MS_REMAIN = 2'b11
  } motor_state_t;

  localparam logic [3:0] COIL_OFF = 4'b0000;

  localparam logic [3:0] PLAYERS_MIN = 4'd2;
  localparam logic [3:0] PLAYERS_MAX = 4'd4;

  function automatic logic [3:0] coil_phase(input logic [1:0] idx);
    logic [3:0] w_coil;
    case (idx)
      2'd0:    w_coil = 4'b0001;
      2'd1:    w_coil = 4'b0010;
      2'd2:    w_coil = 4'b0100;
      default: w_coil = 4'b1000;
    endcase
    return w_coil;
  endfunction

endpackage

// File: rtl/stepper_drv.sv
// rtl/stepper_drv.sv - step-rate divider, forward-only coil phase sequencer and platter position
module stepper_drv
  import dealer_pkg::*;
#(
  parameter int unsigned STEPS_PER_REV = 2048,
  parameter int unsigned STEP_DIV      = 50000,
  localparam int unsigned POS_W = $clog2(STEPS_PER_REV),
  localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  output logic             o_step,
  output logic [3:0]       o_coil,
  output logic [POS_W-1:0] o_pos
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(STEPS_PER_REV - 1);

  logic             r_on;
  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_phase;
  logic [3:0]       r_coil;
  logic [POS_W-1:0] r_pos;
  logic             r_step;

  // i_run is the next-cycle run request, so r_on keeps div_cnt at 0 for the whole entry cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_on      <= 1'b0;
      r_div_cnt <= '0;
      r_phase   <= 2'd0;
      r_coil    <= COIL_OFF;
      r_pos     <= '0;
      r_step    <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (!i_run) begin
        r_on      <= 1'b0;
        r_div_cnt <= '0;
        r_coil    <= COIL_OFF;
      end else begin
        r_on <= 1'b1;
        if (r_on) begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            r_step    <= 1'b1;
            r_coil    <= coil_phase(r_phase);
            r_phase   <= r_phase + 2'd1;
            r_pos     <= (r_pos == POS_LAST) ? '0 : r_pos + POS_W'(1);
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
      end
    end
  end

  assign o_step = r_step;
  assign o_coil = r_coil;
  assign o_pos  = r_pos;

endmodule

// File: rtl/dealer_motor_ctrl.sv
// rtl/dealer_motor_ctrl.sv - round-robin card dealing sequencer driving platter stepper and feed roller
module dealer_motor_ctrl
  import dealer_pkg::*;
#(
  parameter int unsigned STEPS_PER_REV = 2048,
  parameter int unsigned STEP_DIV      = 50000,
  parameter int unsigned DECK_SIZE     = 52,
  parameter int unsigned FEED_TIMEOUT  = 25000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] i_players,
  input  logic       i_card_out,
  output logic [1:0] o_motor_state,
  output logic [3:0] o_coil,
  output logic       o_feed_en,
  output logic       o_jam,
  output logic [5:0] o_remain_cnt
);

  localparam int unsigned POS_W = $clog2(STEPS_PER_REV);
  localparam int unsigned SL_W  = $clog2(STEPS_PER_REV + 1);
  localparam int unsigned CNT_W = $clog2(DECK_SIZE + 1);
  localparam int unsigned TMR_W = $clog2(FEED_TIMEOUT + 1);

  localparam logic [SL_W-1:0]  SPR_FULL = SL_W'(STEPS_PER_REV);
  localparam logic [SL_W-1:0]  SPR_2    = SL_W'(STEPS_PER_REV / 2);
  localparam logic [SL_W-1:0]  SPR_3    = SL_W'(STEPS_PER_REV / 3);
  localparam logic [SL_W-1:0]  SPR_4    = SL_W'(STEPS_PER_REV / 4);
  localparam logic [CNT_W-1:0] DECK_CNT = CNT_W'(DECK_SIZE);
  localparam logic [CNT_W-1:0] QUOTA_2  = CNT_W'((DECK_SIZE / 2) * 2);
  localparam logic [CNT_W-1:0] QUOTA_3  = CNT_W'((DECK_SIZE / 3) * 3);
  localparam logic [CNT_W-1:0] QUOTA_4  = CNT_W'((DECK_SIZE / 4) * 4);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FEED_TIMEOUT - 1);

  motor_state_t     r_state, w_next_state;
  logic [2:0]       r_np, w_np_nxt;
  logic [CNT_W-1:0] r_quota, w_quota_nxt;
  logic [CNT_W-1:0] r_dealt, w_dealt_nxt;
  logic [1:0]       r_seat, w_seat_nxt;
  logic [SL_W-1:0]  r_steps_left, w_steps_left_nxt;
  logic             r_jam, w_jam_nxt;
  logic [5:0]       r_remain, w_remain_nxt;
  logic [TMR_W-1:0] r_timer;
  logic             r_feed_en;

  logic             w_run;
  logic             w_step;
  logic [POS_W-1:0] w_pos;
  logic             w_players_ok;
  logic             w_timeout;
  logic [CNT_W-1:0] w_dealt_inc;
  logic [2:0]       w_seat_inc;
  logic [1:0]       w_new_seat;
  logic [SL_W-1:0]  w_seat_steps;

  stepper_drv #(
    .STEPS_PER_REV(STEPS_PER_REV),
    .STEP_DIV     (STEP_DIV)
  ) u_stepper (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_run (w_run),
    .o_step(w_step),
    .o_coil(o_coil),
    .o_pos (w_pos)
  );

  assign w_players_ok = (i_players >= PLAYERS_MIN) && (i_players <= PLAYERS_MAX);
  assign w_timeout    = (r_timer == TMR_LAST);
  assign w_dealt_inc  = r_dealt + CNT_W'(1);
  assign w_seat_inc   = {1'b0, r_seat} + 3'd1;
  assign w_new_seat   = (w_seat_inc == r_np) ? 2'd0 : w_seat_inc[1:0];
  assign w_seat_steps = (r_np == 3'd2) ? SPR_2 : (r_np == 3'd3) ? SPR_3 : SPR_4;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= MS_RESET;
      r_np         <= 3'd0;
      r_quota      <= '0;
      r_dealt      <= '0;
      r_seat       <= 2'd0;
      r_steps_left <= '0;
      r_jam        <= 1'b0;
      r_remain     <= 6'd0;
      r_timer      <= '0;
      r_feed_en    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_np         <= w_np_nxt;
      r_quota      <= w_quota_nxt;
      r_dealt      <= w_dealt_nxt;
      r_seat       <= w_seat_nxt;
      r_steps_left <= w_steps_left_nxt;
      r_jam        <= w_jam_nxt;
      r_remain     <= w_remain_nxt;
      r_timer      <= (r_state == MS_WAIT && w_next_state == MS_WAIT) ? r_timer + TMR_W'(1) : '0;
      r_feed_en    <= (w_next_state == MS_WAIT);
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_np_nxt         = r_np;
    w_quota_nxt      = r_quota;
    w_dealt_nxt      = r_dealt;
    w_seat_nxt       = r_seat;
    w_steps_left_nxt = r_steps_left;
    w_jam_nxt        = r_jam;
    w_remain_nxt     = r_remain;
    case (r_state)
      MS_RESET: begin
        if (i_start && w_players_ok) begin
          w_np_nxt     = i_players[2:0];
          w_quota_nxt  = (i_players[2:0] == 3'd2) ? QUOTA_2 :
                         (i_players[2:0] == 3'd3) ? QUOTA_3 : QUOTA_4;
          w_dealt_nxt  = '0;
          w_seat_nxt   = 2'd0;
          w_jam_nxt    = 1'b0;
          w_remain_nxt = 6'd0;
          w_next_state = MS_WAIT;
        end
      end
      MS_WAIT: begin
        // a card in the timeout cycle wins over the jam
        if (i_card_out) begin
          w_dealt_nxt = w_dealt_inc;
          if (w_dealt_inc == r_quota) begin
            w_remain_nxt = 6'(DECK_CNT - w_dealt_inc);
            w_next_state = MS_REMAIN;
          end else begin
            w_seat_nxt       = w_new_seat;
            w_steps_left_nxt = (w_new_seat != 2'd0) ? w_seat_steps : SPR_FULL - SL_W'(w_pos);
            w_next_state     = MS_ROTATE;
          end
        end else if (w_timeout) begin
          w_jam_nxt    = 1'b1;
          w_remain_nxt = 6'(DECK_CNT - r_dealt);
          w_next_state = MS_REMAIN;
        end
      end
      MS_ROTATE: begin
        if (w_step) begin
          w_steps_left_nxt = r_steps_left - SL_W'(1);
          if (r_steps_left == SL_W'(1)) begin
            w_next_state = MS_WAIT;
          end
        end
      end
      MS_REMAIN: begin
        if (w_pos == '0) begin
          w_next_state = MS_RESET;
        end
      end
      default: w_next_state = MS_RESET;
    endcase
    w_run = (w_next_state == MS_ROTATE) || (w_next_state == MS_REMAIN && w_pos != '0);
  end

  assign o_motor_state = r_state;
  assign o_feed_en     = r_feed_en;
  assign o_jam         = r_jam;
  assign o_remain_cnt  = r_remain;

endmodule

// File: tb/tb_dealer_motor_ctrl.sv
// tb/tb_dealer_motor_ctrl.sv - scoreboard bench for dealer_motor_ctrl against a deal-level model
module tb_dealer_motor_ctrl;

  localparam int SPR  = 12;
  localparam int SDIV = 2;
  localparam int DECK = 7;
  localparam int TMO  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       card_out = 1'b0;
  logic [3:0] players = 4'd0;
  logic [1:0] motor_state;
  logic [3:0] coil;
  logic       feed_en;
  logic       jam;
  logic [5:0] remain_cnt;

  dealer_motor_ctrl #(
    .STEPS_PER_REV(SPR),
    .STEP_DIV     (SDIV),
    .DECK_SIZE    (DECK),
    .FEED_TIMEOUT (TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_players    (players),
    .i_card_out   (card_out),
    .o_motor_state(motor_state),
    .o_coil       (coil),
    .o_feed_en    (feed_en),
    .o_jam        (jam),
    .o_remain_cnt (remain_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int dur;
    int steps;
    int jam;
    int remain;
  } ev_t;

  ev_t        ev_q[$];
  logic [3:0] coil_q[$];
  int         dq[$];
  int         checks = 0;
  int         passed = 0;
  int         m_pos = 0;
  int         m_steps = 0;
  int         m_jam = 0;
  int         m_remain = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic push_ev(input int st, input int dur, input int steps, input int j, input int rem);
    ev_t e;
    e.st = st; e.dur = dur; e.steps = steps; e.jam = j; e.remain = rem;
    ev_q.push_back(e);
  endtask

  task automatic push_steps(input int k);
    logic [3:0] c;
    for (int s = 0; s < k; s++) begin
      c = 4'b0001 << (m_steps % 4);
      coil_q.push_back(c);
      m_steps++;
      m_pos = (m_pos + 1) % SPR;
    end
  endtask

  // Deal-level reference: seat order, quota and platter angle tracked with plain arithmetic
  task automatic model_deal(input int np, input int dly[$]);
    int quota, dealt, seat, k, jammed;
    quota = (DECK / np) * np;
    dealt = 0; seat = 0; jammed = 0;
    push_ev(2, -1, 0, 0, 0);
    for (int i = 0; i < dly.size(); i++) begin
      if (dly[i] >= TMO) begin
        jammed = 1;
        push_ev(3, TMO, 0, 1, DECK - dealt);
        break;
      end
      dealt++;
      if (dealt == quota) begin
        push_ev(3, dly[i] + 1, 0, 0, DECK - dealt);
        break;
      end
      seat = (seat + 1) % np;
      k = (seat != 0) ? SPR / np : SPR - m_pos;
      push_ev(1, dly[i] + 1, 0, 0, 0);
      push_steps(k);
      push_ev(2, SDIV * k + 1, k, 0, 0);
    end
    k = (SPR - m_pos) % SPR;
    push_steps(k);
    push_ev(0, (k > 0) ? SDIV * k + 1 : 1, k, jammed, DECK - dealt);
    m_jam = jammed;
    m_remain = DECK - dealt;
  endtask

  int         cyc = 0;
  int         entry_cyc = 0;
  int         seen_steps = 0;
  logic [1:0] prev_st = 2'd0;
  logic [3:0] prev_coil = 4'd0;
  ev_t        mon_e;
  logic [3:0] mon_c;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_st = 2'd0; prev_coil = 4'd0; seen_steps = 0; entry_cyc = cyc;
    end else begin
      if (coil !== prev_coil && coil !== 4'd0) begin
        seen_steps++;
        if (coil_q.size() == 0) check("coil_unexpected", coil, 0);
        else begin
          mon_c = coil_q.pop_front();
          check("coil_phase", coil, mon_c);
        end
      end
      prev_coil = coil;
      if (motor_state !== prev_st) begin
        if (ev_q.size() == 0) check("state_unexpected", motor_state, prev_st);
        else begin
          mon_e = ev_q.pop_front();
          check("state", motor_state, mon_e.st);
          if (mon_e.dur >= 0) check("state_duration", cyc - entry_cyc, mon_e.dur);
          check("steps_in_state", seen_steps, mon_e.steps);
          check("entry_coil", coil, 0);
          check("entry_feed_en", feed_en, (mon_e.st == 2) ? 1 : 0);
          check("entry_jam", jam, mon_e.jam);
          check("entry_remain", remain_cnt, mon_e.remain);
        end
        prev_st = motor_state; entry_cyc = cyc; seen_steps = 0;
      end
    end
  end

  task automatic wait_state(input logic [1:0] s, output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (motor_state == s) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic pulse_card();
    card_out = 1'b1;
    @(negedge clk);
    card_out = 1'b0;
  endtask

  task automatic run_deal(input int np, input int dly[$], input bit probe, input bit abort);
    bit ok;
    int quota;
    quota = (DECK / np) * np;
    model_deal(np, dly);
    @(negedge clk);
    players = 4'(np); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < dly.size(); i++) begin
      wait_state(2'd2, ok);
      check("reach_wait", ok, 1);
      if (!ok || dly[i] >= TMO) break;
      repeat (dly[i]) @(negedge clk);
      pulse_card();
      if (i + 1 == quota) break;
      if (probe) begin
        start = 1'b1; card_out = 1'b1;
        @(negedge clk);
        start = 1'b0; card_out = 1'b0;
      end
      if (abort) begin
        for (int w = 0; w < 40 && coil == 4'd0; w++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_coil", coil, 0);
        check("rst_feed_en", feed_en, 0);
        check("rst_state", motor_state, 0);
        check("rst_jam", jam, 0);
        ev_q.delete(); coil_q.delete();
        m_pos = 0; m_steps = 0; m_jam = 0; m_remain = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    @(negedge clk);
    wait_state(2'd0, ok);
    check("reach_reset", ok, 1);
    repeat (3) @(negedge clk);
    check("events_drained", ev_q.size(), 0);
    check("coils_drained", coil_q.size(), 0);
    ev_q.delete(); coil_q.delete();
  endtask

  task automatic illegal(input int p);
    @(negedge clk);
    players = 4'(p); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("illegal_state", motor_state, 0);
    check("illegal_feed_en", feed_en, 0);
    check("illegal_coil", coil, 0);
    check("illegal_jam", jam, m_jam);
    check("illegal_remain", remain_cnt, m_remain);
  endtask

  task automatic rand_deal(input bit probe);
    int np, q;
    np = $urandom_range(2, 4);
    q = (DECK / np) * np;
    dq.delete();
    for (int i = 0; i < q; i++) begin
      if ($urandom_range(0, 11) == 0) begin dq.push_back(TMO); break; end
      dq.push_back($urandom_range(0, TMO - 1));
    end
    run_deal(np, dq, probe, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", motor_state, 0);
    check("reset_coil", coil, 0);
    check("reset_feed_en", feed_en, 0);
    check("reset_jam", jam, 0);
    check("reset_remain", remain_cnt, 0);
    rst = 1'b0;

    dq.delete();
    for (int i = 0; i < 6; i++) dq.push_back(3);
    run_deal(3, dq, 1'b0, 1'b0);

    dq.delete(); dq.push_back(TMO);
    run_deal(2, dq, 1'b0, 1'b0);

    illegal(5); illegal(1); illegal(0); illegal($urandom_range(6, 15));

    dq.delete(); dq.push_back(TMO - 1);
    for (int i = 1; i < 6; i++) dq.push_back(i == 2 ? TMO - 1 : $urandom_range(0, TMO - 1));
    run_deal(2, dq, 1'b0, 1'b0);

    dq.delete(); dq.push_back(2); dq.push_back(4); dq.push_back(4); dq.push_back(4);
    run_deal(4, dq, 1'b0, 1'b1);
    illegal(1);
    dq.delete();
    for (int i = 0; i < 4; i++) dq.push_back($urandom_range(0, TMO - 1));
    run_deal(4, dq, 1'b0, 1'b0);

    dq.delete();
    for (int i = 0; i < 6; i++) dq.push_back($urandom_range(0, 8));
    run_deal(3, dq, 1'b1, 1'b0);

    for (int n = 0; n < 8; n++) rand_deal(n[0]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
